dmem_mmio: RTL and testbench
============================

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving console FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port daddr, input, 32 bits: byte address from the CPU data port.
REQ-006 SHALL have port drdata, output, 32 bits: read data returned to the CPU.
REQ-007 SHALL have port dwdata, input, 32 bits: write data from the CPU.
REQ-008 SHALL have port dwe, input, 4 bits: per-byte-lane write enables; bit i enables dwdata[8i+7:8i].
REQ-009 SHALL have port tx_data, output, 8 bits: console byte at the FIFO head.
REQ-010 SHALL have port tx_valid, output, 1 bit: FIFO non-empty.
REQ-011 SHALL have port tx_ready, input, 1 bit: downstream accepts tx_data.

Function
REQ-012 SHALL decode daddr[31:16]==16'hFFFF as MMIO space; all other addresses SHALL select RAM word daddr[log2(DEPTH_WORDS)+1:2], wrapping modulo DEPTH_WORDS.
REQ-013 SHALL return RAM reads combinationally in the same cycle, ignoring daddr[1:0]; CPU performs byte/half extraction and sign extension.
REQ-014 SHALL write each RAM byte lane whose dwe bit is set on the rising edge; lanes with clear bits SHALL be unchanged.
REQ-015 SHALL return pre-write contents on drdata during a cycle that writes the same word.
REQ-016 SHALL treat MMIO 0xFFFF_0000 (TXDATA) as a write-only register: a write with dwe[0]=1 pushes dwdata[7:0]; reads return 0.
REQ-017 SHALL drop a TXDATA push when the FIFO is full and no pop occurs that cycle, and SHALL set the sticky overflow bit.
REQ-018 SHALL return STATUS on reads of 0xFFFF_0004: bit0 empty, bit1 full, bit2 overflow, bits[7:4] occupancy count, other bits 0.
REQ-019 SHALL clear overflow on a STATUS write with dwe[0]=1 and dwdata[2]=1; all other STATUS write bits are ignored.
REQ-020 SHALL return 0 on reads of unmapped MMIO addresses and ignore writes to them.
REQ-021 SHALL drive tx_valid=!empty and tx_data=head entry, and pop on a rising edge where tx_valid and tx_ready are both 1.
REQ-022 SHALL perform both push and pop on a full FIFO in the same cycle, leaving the count unchanged without setting overflow; on an empty FIFO, push and pop in the same cycle resolves to push only, since tx_valid=0.
REQ-023 SHALL not bypass: a push into an empty FIFO asserts tx_valid from the next cycle.
REQ-024 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-025 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-026 SHALL, while reset=1 at a rising edge, empty the FIFO (pointers and count 0), clear overflow, and zero the cycle counter; tx_valid=0 on the following cycle.
REQ-027 SHALL ignore RAM and MMIO writes in any cycle with reset=1; RAM contents SHALL not be reset.
REQ-028 SHALL discard FIFO contents on reset asserted mid-transfer, with no handshake completed in that cycle.

Configuration
REQ-029 SHALL, with DMEM_CYCLE_COUNTER_EN defined, implement a 32-bit free-running counter incrementing every non-reset cycle and wrapping 0xFFFF_FFFF to 0, readable at 0xFFFF_0008 as its pre-increment register value.
REQ-030 SHALL, without DMEM_CYCLE_COUNTER_EN, contain no counter logic and return 0 on reads of 0xFFFF_0008.

Structure
REQ-031 SHALL take MMIO base and offsets (TXDATA, STATUS, CYCLE) and STATUS bit positions from a shared package dmem_pkg.
REQ-032 SHALL place the console FIFO in sub-module tx_fifo (push, pop, full, empty, count, head data).

Verification
REQ-033 SHALL cover: dwe=4'b1111 writing 0xDEADBEEF to 0x100, then dwe=4'b0001 writing 0x000000AA -> read of 0x100 returns 0xDEADBEAA.
REQ-034 SHALL cover: daddr=DEPTH_WORDS*4+0x10 write 0x12345678 -> read of 0x10 returns 0x12345678.
REQ-035 SHALL cover: 9 TXDATA writes 0x41..0x49 with tx_ready=0 -> STATUS=0x0000_0086, and with tx_ready=1 the bytes 0x41..0x48 drain in order.
REQ-036 SHALL cover: full FIFO, tx_ready=1, TXDATA write 0x5A in the same cycle -> count stays 8, overflow stays 0, 0x5A is last out.
REQ-037 SHALL cover: reset asserted with 3 bytes queued -> next cycle tx_valid=0, STATUS=0x0000_0001, RAM data preserved.
REQ-038 SHALL cover: with DMEM_CYCLE_COUNTER_EN, two CYCLE reads 10 cycles apart differ by 10; without it, reads return 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared MMIO map and STATUS bit layout for the data-memory / console block.
// DMEM_CYCLE_COUNTER_EN (used by dmem_mmio) enables the CYCLE register.
package dmem_pkg;

  localparam logic [15:0] MMIO_BASE  = 16'hFFFF;
  localparam logic [15:0] OFF_TXDATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0004;
  localparam logic [15:0] OFF_CYCLE  = 16'h0008;

  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_W  = 4;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_NONE   = 2'd3
  } mmio_reg_e;

  function automatic mmio_reg_e decode_mmio(input logic [15:0] off);
    case (off)
      OFF_TXDATA: return REG_TXDATA;
      OFF_STATUS: return REG_STATUS;
      OFF_CYCLE:  return REG_CYCLE;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Console transmit FIFO: synchronous, no bypass, push-and-pop allowed when full.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign head_data = mem_r[rptr_r];

  // A pop frees the slot a simultaneous push needs, so full only blocks a lone push.
  assign do_pop_s  = pop && !empty && !reset;
  assign do_push_s = push && (!full || do_pop_s) && !reset;

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r  <= AW'(0);
      rptr_r  <= AW'(0);
      count_r <= CW'(0);
    end else begin
      if (do_push_s) wptr_r <= wptr_r + AW'(1);
      if (do_pop_s)  rptr_r <= rptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wptr_r] <= push_data;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM with byte-lane writes plus console MMIO (TXDATA, STATUS, CYCLE).
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLE counter.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  output logic [31:0] drdata,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAW = $clog2(DEPTH_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic [31:0]    ram_r [DEPTH_WORDS];
  logic [RAW-1:0] word_idx_s;
  logic           is_mmio_s;
  mmio_reg_e      reg_sel_s;
  logic           push_s;
  logic           pop_s;
  logic           ovf_clr_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [CW-1:0]  fifo_count_s;
  logic           overflow_r;
  logic [31:0]    status_s;
  logic [31:0]    cycle_s;
  logic [31:0]    rdata_s;

  assign is_mmio_s  = (daddr[31:16] == MMIO_BASE);
  assign reg_sel_s  = decode_mmio(daddr[15:0]);
  assign word_idx_s = daddr[RAW+1:2];

  assign push_s    = !reset && is_mmio_s && (reg_sel_s == REG_TXDATA) && dwe[0];
  assign ovf_clr_s = !reset && is_mmio_s && (reg_sel_s == REG_STATUS) && dwe[0] && dwdata[ST_OVF];
  assign pop_s     = tx_valid && tx_ready;

  // Byte-lane RAM write; reads see the old word because of the non-blocking update.
  always_ff @(posedge clk) begin
    if (!reset && !is_mmio_s) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) ram_r[word_idx_s][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (dwdata[7:0]),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s),
    .head_data (tx_data)
  );

  assign tx_valid = !fifo_empty_s;

  // Sticky overflow: set by a dropped push, cleared by software or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (push_s && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr_s) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_r;

  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_r <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end

  assign cycle_s = cycle_r;
`else
  assign cycle_s = 32'd0;
`endif

  // STATUS word assembly.
  always_comb begin
    status_s                          = 32'd0;
    status_s[ST_EMPTY]                = fifo_empty_s;
    status_s[ST_FULL]                 = fifo_full_s;
    status_s[ST_OVF]                  = overflow_r;
    status_s[ST_CNT_LO +: ST_CNT_W]   = ST_CNT_W'(fifo_count_s);
  end

  // Read mux: RAM word or MMIO register, TXDATA and unmapped read as zero.
  always_comb begin
    rdata_s = 32'd0;
    if (is_mmio_s) begin
      case (reg_sel_s)
        REG_STATUS: rdata_s = status_s;
        REG_CYCLE:  rdata_s = cycle_s;
        default:    rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = ram_r[word_idx_s];
    end
  end

  assign drdata = rdata_s;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: RAM lanes/wrap, console FIFO scoreboard, reset, CYCLE.
module tb_dmem_mmio;

  localparam int DEPTH_WORDS = 1024;
  localparam int FIFO_DEPTH  = 8;
  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] drdata;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb_q[$];

  dmem_mmio #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .drdata   (drdata),
    .dwdata   (dwdata),
    .dwe      (dwe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one write cycle; the edge after the drive commits it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    daddr  = a;
    dwdata = d;
    dwe    = we;
    @(posedge clk);
    #1;
    dwe = 4'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    daddr = a;
    dwe   = 4'd0;
    #1;
    d = drdata;
  endtask

  task automatic drain(input string tag);
    int cyc;
    @(negedge clk);
    tx_ready = 1'b1;
    cyc = 0;
    while ((sb_q.size() != 0 || tx_valid) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq(tag, sb_q.size(), 32'd0);
    tx_ready = 1'b0;
  endtask

  // Scoreboard monitor: mid-cycle sample of each handshake that the next edge completes.
  always @(negedge clk) begin
    #3;
    if (!reset && tx_valid && tx_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        check_eq("tx_data", {24'd0, tx_data}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [7:0]  b;

    reset    = 1'b1;
    daddr    = 32'd0;
    dwdata   = 32'd0;
    dwe      = 4'd0;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    rd(A_ST, r);  check_eq("rst_status", r, 32'h0000_0001);

    // Byte-lane merge
    wr(32'h100, 32'hDEAD_BEEF, 4'b1111);
    wr(32'h100, 32'h0000_00AA, 4'b0001);
    rd(32'h100, r);  check_eq("ram_lane0", r, 32'hDEAD_BEAA);
    rd(32'h102, r);  check_eq("ram_ign_low", r, 32'hDEAD_BEAA);
    wr(32'h104, 32'h1122_3344, 4'b1111);
    wr(32'h104, 32'hAABB_CCDD, 4'b1010);
    rd(32'h104, r);  check_eq("ram_lane13", r, 32'hAA22_CC44);

    // Address wrap
    wr(DEPTH_WORDS * 4 + 32'h10, 32'h1234_5678, 4'b1111);
    rd(32'h10, r);  check_eq("ram_wrap", r, 32'h1234_5678);

    // Read-during-write returns the old word
    @(negedge clk);
    daddr = 32'h10; dwdata = 32'hCAFE_F00D; dwe = 4'b1111;
    #1;
    check_eq("ram_rdw_old", drdata, 32'h1234_5678);
    @(posedge clk); #1; dwe = 4'd0;
    rd(32'h10, r);  check_eq("ram_rdw_new", r, 32'hCAFE_F00D);

    // Unmapped and write-only MMIO reads
    rd(32'hFFFF_000C, r);  check_eq("mmio_unmapped", r, 32'd0);
    wr(32'hFFFF_000C, 32'hFFFF_FFFF, 4'b1111);
    rd(32'h10, r);  check_eq("mmio_unmapped_wr", r, 32'hCAFE_F00D);

    // Nine pushes with tx_ready low: eight kept, one dropped
    @(negedge clk);
    daddr = A_TX; dwdata = 32'h41; dwe = 4'b0001;
    #1;
    check_eq("no_bypass", {31'd0, tx_valid}, 32'd0);
    sb_q.push_back(8'h41);
    @(posedge clk); #1; dwe = 4'd0;
    for (int i = 1; i < 9; i++) begin
      b = 8'h41 + 8'(i);
      if (i < FIFO_DEPTH) sb_q.push_back(b);
      wr(A_TX, {24'd0, b}, 4'b0001);
    end
    rd(A_TX, r);  check_eq("txdata_read0", r, 32'd0);
    rd(A_ST, r);  check_eq("status_full_ovf", r, 32'h0000_0086);
    check_eq("hold_tx_data", {24'd0, tx_data}, 32'h41);

    // STATUS write without bit2 leaves overflow alone; with bit2 clears it
    wr(A_ST, 32'hFFFF_FFFB, 4'b1111);
    rd(A_ST, r);  check_eq("status_keep_ovf", r, 32'h0000_0086);
    wr(A_ST, 32'h0000_0004, 4'b0001);
    rd(A_ST, r);  check_eq("status_ovf_clr", r, 32'h0000_0082);

    drain("drain_41_48");
    rd(A_ST, r);  check_eq("status_empty", r, 32'h0000_0001);

    // Full FIFO: push and pop in one cycle
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      b = 8'h61 + 8'(i);
      sb_q.push_back(b);
      wr(A_TX, {24'd0, b}, 4'b0001);
    end
    @(negedge clk);
    daddr = A_TX; dwdata = 32'h5A; dwe = 4'b0001; tx_ready = 1'b1;
    sb_q.push_back(8'h5A);
    @(posedge clk); #1;
    dwe = 4'd0; tx_ready = 1'b0;
    rd(A_ST, r);  check_eq("full_push_pop", r, 32'h0000_0082);
    drain("drain_5a_last");

    // Reset with three bytes queued, with a RAM write and ready in that cycle
    for (int i = 0; i < 3; i++) begin
      wr(A_TX, 32'h31 + i, 4'b0001);
    end
    @(negedge clk);
    reset = 1'b1; daddr = 32'h100; dwdata = 32'h0; dwe = 4'b1111; tx_ready = 1'b1;
    @(posedge clk); #1;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0; dwe = 4'd0; tx_ready = 1'b0;
    check_eq("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
    rd(A_ST, r);  check_eq("rst_mid_status", r, 32'h0000_0001);
    rd(32'h100, r);  check_eq("rst_ram_kept", r, 32'hDEAD_BEAA);

    // CYCLE register
    @(negedge clk);
    daddr = A_CYC; dwe = 4'd0;
    #1; c1 = drdata;
    repeat (10) @(negedge clk);
    #1; c2 = drdata;
`ifdef DMEM_CYCLE_COUNTER_EN
    check_eq("cycle_delta", c2 - c1, 32'd10);
`else
    check_eq("cycle_off_a", c1, 32'd0);
    check_eq("cycle_off_b", c2, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
